entrada_jogada: RTL and testbench

Input front-end for the memory game, upstream of the game datapath and control unit. It synchronizes and debounces the four raw buttons and registers each play as a 4-bit `jogada`. It issues exactly one `tem_jogada` pulse per press. It also runs the per-play timeout timer that the control unit consumes to declare a loss by timeout.

---
 rtl/entrada_jogada.sv | 151 +++++++++++++++
 tb/tb_entrada_jogada.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/entrada_jogada.sv
// Memory-game input front-end: button sync, debounce and play capture.
// Also hosts the per-play timeout counter used by the control unit.
module entrada_jogada #(
  parameter int N_DEBOUNCE = 3,
  parameter int TIMEOUT    = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita_espera,
  input  logic       zera_timeout,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_valida,
  output logic       timeout,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(N_DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(N_DEBOUNCE - 1);
  localparam logic [CW-1:0] DB_ONE  = CW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_FULL = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESTABILIZANDO = 2'd1,
    PRESSIONADO   = 2'd2,
    SOLTANDO      = 2'd3
  } estado_t;

  estado_t       estado;
  estado_t       estado_nx;
  logic [3:0]    botoes_m;
  logic [3:0]    botoes_s;
  logic [3:0]    amostra;
  logic [3:0]    amostra_nx;
  logic [CW-1:0] cnt_db;
  logic [CW-1:0] cnt_db_nx;
  logic [3:0]    jogada_nx;
  logic          pulso_nx;
  logic [TW-1:0] cnt_to;
  logic          espera_ativa;

  // two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_m <= '0;
      botoes_s <= '0;
    end else begin
      botoes_m <= botoes;
      botoes_s <= botoes_m;
    end
  end

  // debounce FSM state, sample, counter and captured play
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      amostra    <= '0;
      cnt_db     <= '0;
      jogada     <= '0;
      tem_jogada <= 1'b0;
    end else begin
      estado     <= estado_nx;
      amostra    <= amostra_nx;
      cnt_db     <= cnt_db_nx;
      jogada     <= jogada_nx;
      tem_jogada <= pulso_nx;
    end
  end

  // next-state logic: accept a press once stable, then demand a full release
  always_comb begin
    estado_nx  = estado;
    amostra_nx = amostra;
    cnt_db_nx  = cnt_db;
    jogada_nx  = jogada;
    pulso_nx   = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (botoes_s != 4'b0000) begin
          amostra_nx = botoes_s;
          cnt_db_nx  = '0;
          estado_nx  = ESTABILIZANDO;
        end
      end
      ESTABILIZANDO: begin
        if (botoes_s == 4'b0000) begin
          estado_nx = OCIOSO;
        end else if (botoes_s != amostra) begin
          amostra_nx = botoes_s;
          cnt_db_nx  = '0;
        end else if (cnt_db == DB_LAST) begin
          jogada_nx = amostra;
          pulso_nx  = 1'b1;
          estado_nx = PRESSIONADO;
        end else begin
          cnt_db_nx = cnt_db + DB_ONE;
        end
      end
      PRESSIONADO: begin
        if (botoes_s == 4'b0000) begin
          cnt_db_nx = '0;
          estado_nx = SOLTANDO;
        end
      end
      SOLTANDO: begin
        if (botoes_s != 4'b0000) begin
          estado_nx = PRESSIONADO;
        end else if (cnt_db == DB_LAST) begin
          estado_nx = OCIOSO;
        end else begin
          cnt_db_nx = cnt_db + DB_ONE;
        end
      end
      default: estado_nx = OCIOSO;
    endcase
  end

  // the wait only runs while no button is being held or released
  assign espera_ativa = habilita_espera && !timeout &&
                        (estado == OCIOSO || estado == ESTABILIZANDO);

  // timeout counter; a play clears it, a clear request clears the flag too
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_to  <= '0;
      timeout <= 1'b0;
    end else if (zera_timeout) begin
      cnt_to  <= '0;
      timeout <= 1'b0;
    end else if (tem_jogada) begin
      cnt_to <= '0;
    end else if (espera_ativa) begin
      if (cnt_to == TO_LAST) begin
        cnt_to  <= TO_FULL;
        timeout <= 1'b1;
      end else begin
        cnt_to <= cnt_to + TO_ONE;
      end
    end
  end

  assign jogada_valida = $onehot(jogada);
  assign db_estado     = estado;

endmodule

// File: tb/tb_entrada_jogada.sv
// Directed bench for entrada_jogada with TIMEOUT=20, N_DEBOUNCE=3.
// Inputs change 1ns after each rising edge; outputs are read there too.
module tb_entrada_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita_espera;
  logic       zera_timeout;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_valida;
  logic       timeout;
  logic [1:0] db_estado;

  int vecs = 0;
  int errs = 0;
  int pulses;
  int first_at;

  entrada_jogada #(
    .N_DEBOUNCE(3),
    .TIMEOUT(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .botoes(botoes),
    .habilita_espera(habilita_espera),
    .zera_timeout(zera_timeout),
    .jogada(jogada),
    .tem_jogada(tem_jogada),
    .jogada_valida(jogada_valida),
    .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    pulses   = 0;
    first_at = 0;
  endtask

  // hold b for n cycles, counting pulses and the first pulse index
  task automatic run(input int n, input logic [3:0] b);
    botoes = b;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (tem_jogada) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    botoes = 4'b0000;
    habilita_espera = 1'b0;
    zera_timeout = 1'b0;
    tick();
    tick();
    chk("rst_jogada", int'(jogada), 0);
    chk("rst_tem", int'(tem_jogada), 0);
    chk("rst_valida", int'(jogada_valida), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_db", int'(db_estado), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_db", int'(db_estado), 0);
      chk("idle_tem", int'(tem_jogada), 0);
    end

    // single press of 0001
    clr();
    run(2, 4'b0001);
    chk("p1_db_sync", int'(db_estado), 0);
    run(1, 4'b0001);
    chk("p1_db_estab", int'(db_estado), 1);
    run(2, 4'b0001);
    chk("p1_db_estab2", int'(db_estado), 1);
    chk("p1_early", pulses, 0);
    run(1, 4'b0001);
    chk("p1_db_press", int'(db_estado), 2);
    chk("p1_tem", int'(tem_jogada), 1);
    run(4, 4'b0001);
    chk("p1_pulses", pulses, 1);
    chk("p1_jogada", int'(jogada), 1);
    chk("p1_valida", int'(jogada_valida), 1);
    run(3, 4'b0000);
    chk("p1_db_solt", int'(db_estado), 3);
    run(7, 4'b0000);
    chk("p1_db_idle", int'(db_estado), 0);
    chk("p1_no_second", pulses, 1);

    // bounce on 0100
    clr();
    run(2, 4'b0100);
    run(1, 4'b0000);
    chk("b_burst", pulses, 0);
    run(10, 4'b0100);
    chk("b_pulses", pulses, 1);
    chk("b_jogada", int'(jogada), 4);
    chk("b_valida", int'(jogada_valida), 1);
    run(10, 4'b0000);
    chk("b_db_idle", int'(db_estado), 0);

    // two buttons at once
    clr();
    run(10, 4'b0011);
    chk("m_pulses", pulses, 1);
    chk("m_jogada", int'(jogada), 3);
    chk("m_valida", int'(jogada_valida), 0);
    run(10, 4'b0000);

    // timeout from idle, sticky, then cleared
    habilita_espera = 1'b1;
    run(19, 4'b0000);
    chk("t_before", int'(timeout), 0);
    run(1, 4'b0000);
    chk("t_set", int'(timeout), 1);
    run(5, 4'b0000);
    chk("t_sticky", int'(timeout), 1);
    zera_timeout = 1'b1;
    run(1, 4'b0000);
    zera_timeout = 1'b0;
    chk("t_cleared", int'(timeout), 0);

    // holding 1000 pauses the count; counting resumes once idle
    clr();
    run(30, 4'b1000);
    chk("h_pulses", pulses, 1);
    chk("h_jogada", int'(jogada), 8);
    chk("h_paused", int'(timeout), 0);
    run(25, 4'b0000);
    chk("h_rel_before", int'(timeout), 0);
    run(1, 4'b0000);
    chk("h_rel_set", int'(timeout), 1);

    // pulse lands while counter is TIMEOUT-1
    zera_timeout = 1'b1;
    run(1, 4'b0000);
    zera_timeout = 1'b0;
    run(13, 4'b0000);
    clr();
    run(6, 4'b0001);
    chk("c_first", first_at, 6);
    chk("c_no_to", int'(timeout), 0);
    run(24, 4'b0001);
    chk("c_held", int'(timeout), 0);
    run(25, 4'b0000);
    chk("c_rel_before", int'(timeout), 0);
    run(1, 4'b0000);
    chk("c_rel_set", int'(timeout), 1);

    // reset while the button is held
    habilita_espera = 1'b0;
    zera_timeout = 1'b1;
    run(1, 4'b0000);
    zera_timeout = 1'b0;
    run(10, 4'b0000);
    clr();
    run(8, 4'b0010);
    chk("r_pre_db", int'(db_estado), 2);
    reset = 1'b1;
    run(1, 4'b0010);
    reset = 1'b0;
    chk("r_db", int'(db_estado), 0);
    chk("r_jogada", int'(jogada), 0);
    chk("r_tem", int'(tem_jogada), 0);
    clr();
    run(10, 4'b0010);
    chk("r_first", first_at, 6);
    chk("r_pulses", pulses, 1);
    chk("r_jogada2", int'(jogada), 2);
    chk("r_valida", int'(jogada_valida), 1);
    run(10, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
